// File: rtl/core_pkg.sv
// Shared core-wide sizing for the integer register file and its users.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   xlen_t;

endpackage : core_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port: decode of the stored array, write-to-read
// forwarding (highest write port wins), x0 force and busy qualification.
module regfile_read_port #(
    parameter int XLEN    = core_pkg::XLEN,
    parameter int NREGS   = core_pkg::NREGS,
    parameter int AW      = $clog2(NREGS),
    parameter int NWR     = 2,
    parameter bit ZERO_X0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic                        reset_i,
    input  logic [AW-1:0]               rd_addr_i,
    input  logic [NWR-1:0]              wr_en_i,
    input  logic [NWR*AW-1:0]           wr_addr_i,
    input  logic [NWR*XLEN-1:0]         wr_data_i,
    input  logic [NWR-1:0]              wr_clr_i,
    input  logic [NREGS-1:0][XLEN-1:0]  regs_i,
    input  logic [NREGS-1:0]            busy_i,
    output logic [XLEN-1:0]             rd_data_o,
    output logic                        rd_busy_o
);

    logic clr_hit;

    // Select stored value, override with the highest matching same-cycle write,
    // then apply the x0 and reset forcing.
    always_comb begin
        rd_data_o = regs_i[rd_addr_i];
        clr_hit   = 1'b0;
        if (BYPASS) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i)) begin
                    rd_data_o = wr_data_i[j*XLEN +: XLEN];
                    clr_hit   = clr_hit | wr_clr_i[j];
                end
            end
        end
        // A retiring write in this cycle already carries the value, so the
        // consumer need not stall on it.
        rd_busy_o = busy_i[rd_addr_i] & ~clr_hit;
        if (ZERO_X0 && (rd_addr_i == '0)) begin
            rd_data_o = '0;
            rd_busy_o = 1'b0;
        end
        // Forwarded write data must not leak out while reset is held.
        if (!reset_i) begin
            rd_data_o = '0;
            rd_busy_o = 1'b0;
        end
    end

endmodule : regfile_read_port

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with per-register busy scoreboard.
// Reads are combinational (ID stage), writes and scoreboard update on posedge.
module regfile_mp_scoreboard #(
    parameter int XLEN    = core_pkg::XLEN,
    parameter int NREGS   = core_pkg::NREGS,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter bit ZERO_X0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NRD*$clog2(NREGS)-1:0]  rd_addr,
    output logic [NRD*XLEN-1:0]           rd_data,
    output logic [NRD-1:0]                rd_busy,
    input  logic [NWR-1:0]                wr_en,
    input  logic [NWR*$clog2(NREGS)-1:0]  wr_addr,
    input  logic [NWR*XLEN-1:0]           wr_data,
    input  logic [NWR-1:0]                wr_clr,
    input  logic                          iss_valid,
    input  logic [$clog2(NREGS)-1:0]      iss_rd,
    input  logic                          flush,
    output logic [NREGS-1:0]              busy_vec
);

    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           busy_q, busy_d;

    // Apply write ports in ascending order so the highest index wins a collision.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && !(ZERO_X0 && (wr_addr[j*AW +: AW] == '0))) begin
                regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
            end
        end
    end

    // Scoreboard next state: clears first, then a new issue re-sets, flush last.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && wr_clr[j]) begin
                busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_valid && !(ZERO_X0 && (iss_rd == '0))) begin
            busy_d[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    // Architectural state; async reset drops every register and busy bit at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_read_port #(
            .XLEN    (XLEN),
            .NREGS   (NREGS),
            .AW      (AW),
            .NWR     (NWR),
            .ZERO_X0 (ZERO_X0),
            .BYPASS  (BYPASS)
        ) u_rd (
            .reset_i   (reset),
            .rd_addr_i (rd_addr[i*AW +: AW]),
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .wr_clr_i  (wr_clr),
            .regs_i    (regs_q),
            .busy_i    (busy_q),
            .rd_data_o (rd_data[i*XLEN +: XLEN]),
            .rd_busy_o (rd_busy[i])
        );
    end

endmodule : regfile_mp_scoreboard
